// File: rtl/audio_sample_fifo_pkg.sv
// Shared definitions for the audio sample front end.
//   CODEC_WIDTH  : width of one codec channel sample (signed)
//   SAMPLE_WIDTH : width of the DFT input sample (signed)
//   SUM_WIDTH    : width of the left+right channel sum (cannot overflow)
//   state_e      : codec read sequencer states
//   sat_narrow() : clamps a signed channel sum to the signed sample range
package CCHW;

    localparam int unsigned CODEC_WIDTH  = 24;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned SUM_WIDTH    = CODEC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic signed [SUM_WIDTH-1:0] SAMPLE_MAX = 25'sh0007FFF;
    localparam logic signed [SUM_WIDTH-1:0] SAMPLE_MIN = 25'sh1FF8000;

    function automatic logic [SAMPLE_WIDTH-1:0] sat_narrow(
        input logic signed [SUM_WIDTH-1:0] v
    );
        if (v > SAMPLE_MAX) begin
            return 16'h7FFF;
        end else if (v < SAMPLE_MIN) begin
            return 16'h8000;
        end else begin
            return v[SAMPLE_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/audio_sample_fifo_sample_fifo.sv
// sample_fifo: synchronous showahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i (accepted when not full, or when popping)
//   pop_i      : remove head (ignored when empty)
//   data_o     : registered head entry
//   full_o     : occupancy equals DEPTH
//   empty_o    : registered, low when at least one entry is held
//   level_o    : current occupancy, 0..DEPTH
module sample_fifo
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok = push_i && ((count_q != LW'(DEPTH)) || pop_ok);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        head_d  = head_q;
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok) begin
            wr_d = wr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head register: next entry comes from memory, or straight from the
        // write port when the FIFO is (or is about to be) otherwise empty.
        // When full, the incoming write lands in the slot being vacated, never
        // in rd_q+1, so the memory read below is always the older entry.
        if (pop_ok) begin
            if (count_q > LW'(1)) begin
                head_d = mem_q[rd_q + 1'b1];
            end else if (push_ok) begin
                head_d = data_i;
            end
        end else if (push_ok && (count_q == '0)) begin
            head_d = data_i;
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
            empty_q <= empty_d;
        end
    end

    assign data_o  = head_q;
    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = empty_q;
    assign level_o = count_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: codec read sequencer + L/R sum/scale + sample FIFO.
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   readReady      : codec has a sample; readDataLeft/Right valid while high
//   readDataLeft   : 24-bit signed left sample
//   readDataRight  : 24-bit signed right sample
//   codecRead      : single-cycle pop strobe to the codec
//   sampleOut      : 16-bit signed FIFO head, valid when sampleValid
//   sampleValid    : FIFO not empty
//   sampleTake     : consumer pops head when sampleValid && sampleTake
//   fillLevel      : FIFO occupancy
//   overflowCount  : saturating count of samples dropped on a full FIFO
// Build option: AUDIO_FIFO_SAT_EN clamps out-of-range scaled samples to
// 0x7FFF/0x8000; without it the scaled sum is truncated (wraps).
module audio_sample_fifo
    import CCHW::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SHIFT = 8
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         readReady,
    input  logic [CODEC_WIDTH-1:0]       readDataLeft,
    input  logic [CODEC_WIDTH-1:0]       readDataRight,
    output logic                         codecRead,
    output logic [SAMPLE_WIDTH-1:0]      sampleOut,
    output logic                         sampleValid,
    input  logic                         sampleTake,
    output logic [$clog2(DEPTH):0]       fillLevel,
    output logic [15:0]                  overflowCount
);

    state_e                    state_q, state_d;
    logic [SAMPLE_WIDTH-1:0]   sample_q, sample_d;
    logic                      codec_read_q, codec_read_d;
    logic [15:0]               ovf_q, ovf_d;

    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [SUM_WIDTH-1:0] scaled;
    logic [SAMPLE_WIDTH-1:0]     converted;

    logic push, pop, drop, fifo_full, fifo_empty;

    assign sum    = {readDataLeft[CODEC_WIDTH-1], readDataLeft}
                  + {readDataRight[CODEC_WIDTH-1], readDataRight};
    assign scaled = sum >>> SHIFT;

    always_comb begin
`ifdef AUDIO_FIFO_SAT_EN
        converted = sat_narrow(scaled);
`else
        converted = scaled[SAMPLE_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        unique case (state_q)
            IDLE: begin
                if (readReady) begin
                    sample_d = converted;
                    state_d  = READ;
                end
            end
            READ:    state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobe register tracks "next state is READ" so the pulse is a flop
        // output aligned exactly with the READ cycle.
        codec_read_d = (state_d == READ);
    end

    assign push = (state_q == READ);
    assign pop  = sampleValid && sampleTake;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            codec_read_q <= 1'b0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            codec_read_q <= codec_read_d;
            ovf_q        <= ovf_d;
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (sample_q),
        .data_o  (sampleOut),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fillLevel)
    );

    assign sampleValid   = !fifo_empty;
    assign codecRead     = codec_read_q;
    assign overflowCount = ovf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo (DEPTH=8, SHIFT=8).
// Reference model: a sample queue plus a read-sequencer phase counter.
module tb_audio_sample_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SHIFT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        readReady = 1'b0;
    logic [23:0] readDataLeft = '0;
    logic [23:0] readDataRight = '0;
    logic        codecRead;
    logic [15:0] sampleOut;
    logic        sampleValid;
    logic        sampleTake = 1'b0;
    logic [3:0]  fillLevel;
    logic [15:0] overflowCount;

    always #5 clk = ~clk;

    audio_sample_fifo #(
        .DEPTH (DEPTH),
        .SHIFT (SHIFT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .readReady     (readReady),
        .readDataLeft  (readDataLeft),
        .readDataRight (readDataRight),
        .codecRead     (codecRead),
        .sampleOut     (sampleOut),
        .sampleValid   (sampleValid),
        .sampleTake    (sampleTake),
        .fillLevel     (fillLevel),
        .overflowCount (overflowCount)
    );

    int total = 0;
    int bad   = 0;

    // model state: queue of pending samples, phase 2=READ,1=SETTLE,0=IDLE
    logic [15:0] mq[$];
    int          m_ovf   = 0;
    int          m_phase = 0;
    logic [15:0] m_pend  = '0;
    int          strobes = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] conv(input logic [23:0] l, input logic [23:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> SHIFT;
`ifdef AUDIO_FIFO_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 0;
        m_phase = 0;
    endtask

    task automatic check_all();
        chk("codecRead", {31'd0, codecRead}, {31'd0, (m_phase == 2)});
        chk("sampleValid", {31'd0, sampleValid}, {31'd0, (mq.size() > 0)});
        chk("fillLevel", {28'd0, fillLevel}, mq.size());
        chk("overflowCount", {16'd0, overflowCount}, m_ovf);
        if (mq.size() > 0) chk("sampleOut", {16'd0, sampleOut}, {16'd0, mq[0]});
    endtask

    // Apply inputs for one cycle, advance the model to the next edge, compare.
    task automatic step(input logic rr, input logic [23:0] l, input logic [23:0] r, input logic take);
        logic do_pop;
        readReady     = rr;
        readDataLeft  = l;
        readDataRight = r;
        sampleTake    = take;
        do_pop = (mq.size() > 0) && take;
        if (do_pop) void'(mq.pop_front());
        if (m_phase == 2) begin
            if (mq.size() < DEPTH) mq.push_back(m_pend);
            else if (m_ovf < 65535) m_ovf++;
        end
        if (m_phase == 0) begin
            if (rr) begin
                m_pend  = conv(l, r);
                m_phase = 2;
            end
        end else begin
            m_phase--;
        end
        @(posedge clk);
        #1;
        if (codecRead) strobes++;
        check_all();
    endtask

    initial begin
        logic [15:0] exp;
        int last;
        int guard;

        tv[0] = '{24'h000100, 24'h000200, 16'h0003, 16'h0003};
        tv[1] = '{24'h7FFFFF, 24'h7FFFFF, 16'hFFFF, 16'h7FFF};
        tv[2] = '{24'h800000, 24'h800000, 16'h0000, 16'h8000};
        tv[3] = '{24'h400000, 24'h400000, 16'h8000, 16'h7FFF};
        tv[4] = '{24'hFFFF00, 24'h000000, 16'hFFFF, 16'hFFFF};
        tv[5] = '{24'h123456, 24'h000000, 16'h1234, 16'h1234};
        tv[6] = '{24'hFFFFFF, 24'hFFFFFF, 16'hFFFF, 16'hFFFF};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_codecRead", {31'd0, codecRead}, 32'd0);
        chk("rst_sampleValid", {31'd0, sampleValid}, 32'd0);
        chk("rst_sampleOut", {16'd0, sampleOut}, 32'd0);
        chk("rst_fillLevel", {28'd0, fillLevel}, 32'd0);
        chk("rst_overflow", {16'd0, overflowCount}, 32'd0);
        rst = 1'b1;
        model_reset();

        // conversion table: one transaction each, 2-cycle latency
        for (int i = 0; i < 7; i++) begin
`ifdef AUDIO_FIFO_SAT_EN
            exp = tv[i].exp_sat;
`else
            exp = tv[i].exp_wrap;
`endif
            step(1'b1, tv[i].l, tv[i].r, 1'b0);
            chk("tv_strobe_c1", {31'd0, codecRead}, 32'd1);
            chk("tv_valid_c1", {31'd0, sampleValid}, 32'd0);
            step(1'b0, '0, '0, 1'b0);
            chk("tv_strobe_c2", {31'd0, codecRead}, 32'd0);
            chk("tv_valid_c2", {31'd0, sampleValid}, 32'd1);
            chk("tv_sample", {16'd0, sampleOut}, {16'd0, exp});
            step(1'b0, '0, '0, 1'b1);
            chk("tv_drained", {31'd0, sampleValid}, 32'd0);
        end

        // continuous readReady with a fast consumer: strobe every 3 cycles
        last = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 24'($urandom), 24'($urandom), 1'b1);
            if (codecRead) begin
                if (last >= 0) chk("strobe_gap", i - last, 3);
                last = i;
            end
        end
        repeat (4) step(1'b0, '0, '0, 1'b1);

        // overflow: 10 samples into an 8-deep FIFO with no consumer
        strobes = 0;
        guard = 0;
        while (strobes < 10 && guard < 40) begin
            step(1'b1, 24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        chk("ovf_strobe_count", strobes, 10);
        repeat (3) step(1'b0, '0, '0, 1'b0);
        chk("ovf_fill", {28'd0, fillLevel}, 32'd8);
        chk("ovf_count", {16'd0, overflowCount}, 32'd2);
        step(1'b1, 24'h000300, 24'h000300, 1'b0);
        chk("full_strobe", {31'd0, codecRead}, 32'd1);
        step(1'b0, '0, '0, 1'b1);
        chk("pushpop_fill", {28'd0, fillLevel}, 32'd8);
        chk("pushpop_ovf", {16'd0, overflowCount}, 32'd2);
        repeat (12) step(1'b0, '0, '0, 1'b1);
        chk("drain_empty", {31'd0, sampleValid}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 24'($urandom), 24'($urandom), ($urandom_range(0, 1) == 1));
        end
        repeat (3) step(1'b0, '0, '0, 1'b0);

        // reset while in READ with data buffered
        step(1'b1, 24'h000500, 24'h000500, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, 24'h000100, 24'h000100, 1'b0);
        chk("pre_rst_strobe", {31'd0, codecRead}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_codecRead", {31'd0, codecRead}, 32'd0);
        chk("midrst_sampleValid", {31'd0, sampleValid}, 32'd0);
        chk("midrst_fillLevel", {28'd0, fillLevel}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 24'h000100, 24'h000200, 1'b0);
        chk("postrst_strobe", {31'd0, codecRead}, 32'd1);
        step(1'b0, '0, '0, 1'b0);
        chk("postrst_valid", {31'd0, sampleValid}, 32'd1);
        chk("postrst_sample", {16'd0, sampleOut}, 32'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Single-clock front end between the audio codec's read port and the ColorChord DFT input. It issues exactly one single-cycle read strobe per codec sample, sums left and right channels, scales them to the 16-bit DFT sample width, and buffers the results in a small FIFO. The consumer drains the FIFO through a valid/take handshake, so a slow or bursty consumer never stretches the codec read strobe or misses samples.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- SHIFT, 8: right arithmetic shift applied to the 25-bit channel sum before narrowing to 16 bits.
- clk  input  1  system clock (codec clock domain, 50 MHz).
- rst  input  1  reset, asynchronous, active-low.
- readReady  input  1  codec has a sample available; data valid while high.
- readDataLeft  input  24  codec left sample, signed.
- readDataRight  input  24  codec right sample, signed.
- codecRead  output  1  single-cycle pop strobe to the codec.
- sampleOut  output  16  FIFO head sample, signed; valid when sampleValid is high.
- sampleValid  output  1  FIFO not empty.
- sampleTake  input  1  consumer pops the head on any cycle where sampleValid && sampleTake.
- fillLevel  output  $clog2(DEPTH)+1  current occupancy.
- overflowCount  output  16  samples dropped because the FIFO was full; saturates at 0xFFFF.

## Operation
- Reset (rst low, asynchronous): state IDLE, FIFO empty, codecRead=0, sampleValid=0, sampleOut=0, fillLevel=0, overflowCount=0.
- FSM states:
  - IDLE: when readReady=1, register the converted sample and go to READ.
  - READ: codecRead=1 for exactly this cycle; push the registered sample, or drop it if full; go to SETTLE.
  - SETTLE: codecRead=0; ignore readReady for one cycle while the codec status updates; go to IDLE.
- Minimum spacing between codecRead strobes is 3 cycles.
- Conversion:
  - sum = sign-extend(L) + sign-extend(R), 25 bits, never overflows.
  - scaled = sum >>> SHIFT.
  - Narrowing to 16 bits follows the Configuration section.
- Push while full: the sample is dropped and overflowCount increments. The codec is still acknowledged so its own buffer keeps draining.
- Push and pop in the same cycle:
  - FIFO full: the pop frees a slot, the push is accepted, fillLevel is unchanged, no drop.
  - FIFO empty: no pop, because sampleValid=0.
- sampleTake while sampleValid=0 is ignored.
- Pointers wrap modulo DEPTH. fillLevel distinguishes full (DEPTH) from empty (0).

## Timing
- Cycle 0: IDLE with readReady=1; data captured at the end of cycle 0.
- Cycle 1: codecRead=1; FIFO write at the end of cycle 1.
- Cycle 2: sampleValid=1 and sampleOut=sample, if the FIFO was empty. Latency is 2 cycles from readReady to sampleValid.
- Pop: when sampleValid && sampleTake in cycle n, sampleOut shows the next entry in cycle n+1, or sampleValid drops if no entry remains.
- All outputs are registered. sampleOut is the showahead head register.
- Reset asserted mid-transaction forces IDLE immediately; any pending strobe is lost. No codecRead is generated until at least one full cycle after rst deasserts.

## Configuration
- AUDIO_FIFO_SAT_EN defined: scaled values outside [-32768, 32767] clamp to 0x8000 or 0x7FFF.
- AUDIO_FIFO_SAT_EN undefined: plain truncation, sampleOut = sum[SHIFT+15:SHIFT]; wraps on overflow.

## Structure
- Shared package CCHW holds:
  - CODEC_WIDTH=24 and SAMPLE_WIDTH=16.
  - The FSM state enum (IDLE, READ, SETTLE).
  - A saturating narrowing function.
- One sub-module: sample_fifo, a synchronous showahead FIFO with push, pop, full, empty and level outputs, parameterised by width and DEPTH.

## Test plan
- Reset, then readReady=1 with L=0x000100 and R=0x000200, SHIFT=8 → exactly one codecRead pulse in cycle 1; sampleValid in cycle 2 with sampleOut=0x0003.
- readReady held high continuously, sampleTake=1 → codecRead pulses every 3 cycles; samples emerge in order with no duplicates.
- L=R=0x7FFFFF, SHIFT=8:
  - With AUDIO_FIFO_SAT_EN → sampleOut=0x7FFF.
  - Without it → sampleOut=0xFFFF (sum[23:8] of 0x0FFFFFE).
- sampleTake=0, DEPTH=8, 10 codec samples → fillLevel=8, overflowCount=2, and codecRead still pulses 10 times. Then one pop with a simultaneous push → fillLevel stays 8 and overflowCount stays 2.
- Assert rst while in the READ state → codecRead, sampleValid and fillLevel are 0 in the same cycle; after release the next readReady produces a normal 2-cycle-latency sample.
